// File: rtl/dac_frame_sequencer.sv
// I2S DAC frame sequencer: pulls L/R pairs from the sample FIFO and shifts
// them MSB-first on DACDAT, one BCLK delay after each LRCLK edge.
module dac_frame_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  bclk_rising_edge,
   input  logic                  bclk_falling_edge,
   input  logic                  lrclk_rising_edge,
   input  logic                  lrclk_falling_edge,
   input  logic [DATA_WIDTH-1:0] left_data,
   input  logic [DATA_WIDTH-1:0] right_data,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic                  serial_data,
   output logic                  busy,
   output logic                  underflow,
   output logic [CNT_WIDTH-1:0]  underflow_count
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] FULL = BW'(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] right_hold;
   logic [BW-1:0]         bit_cnt;

   logic lr_fall;
   logic lr_rise;
   logic start;
   logic load_r;
   logic stop;
   logic unused_bclk_rise;

   // Simultaneous LRCLK strobes are illegal and cancel each other.
   assign lr_fall = lrclk_falling_edge & ~lrclk_rising_edge;
   assign lr_rise = lrclk_rising_edge & ~lrclk_falling_edge;

   assign start  = lr_fall & enable & (state == IDLE || state == RIGHT);
   assign load_r = lr_rise & (state == LEFT);
   assign stop   = lr_fall & ~enable & (state == RIGHT);

   assign unused_bclk_rise = bclk_rising_edge;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         shift_reg       <= '0;
         right_hold      <= '0;
         bit_cnt         <= '0;
         serial_data     <= 1'b0;
         data_ready      <= 1'b0;
         busy            <= 1'b0;
         underflow       <= 1'b0;
         underflow_count <= '0;
      end else begin
         data_ready <= 1'b0;
         underflow  <= 1'b0;
         if (start) begin
            state   <= LEFT;
            busy    <= 1'b1;
            bit_cnt <= FULL;
            if (data_valid) begin
               shift_reg  <= left_data;
               right_hold <= right_data;
               data_ready <= 1'b1;
            end else begin
               shift_reg  <= '0;
               right_hold <= '0;
               underflow  <= 1'b1;
               if (underflow_count != '1)
                  underflow_count <= underflow_count + 1'b1;
            end
            // The BCLK edge coinciding with the load is the I2S delay slot.
            if (bclk_falling_edge)
               serial_data <= 1'b0;
         end else if (load_r) begin
            state     <= RIGHT;
            busy      <= 1'b1;
            shift_reg <= right_hold;
            bit_cnt   <= FULL;
            if (bclk_falling_edge)
               serial_data <= 1'b0;
         end else if (stop) begin
            state       <= IDLE;
            busy        <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            serial_data <= 1'b0;
         end else if (state != IDLE && bclk_falling_edge) begin
            if (bit_cnt != '0) begin
               serial_data <= shift_reg[DATA_WIDTH-1];
               shift_reg   <= shift_reg << 1;
               bit_cnt     <= bit_cnt - 1'b1;
            end else begin
               serial_data <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/dac_frame_sequencer.md
Name: dac_frame_sequencer

Overview:
- Sequences the audio DAC serial path: fetches left/right sample pairs from the upstream sample buffer and shifts them out MSB-first in I2S format.
- Runs entirely in the system clock domain. Codec timing arrives as single-cycle edge strobes from the clock-edge detectors on BCLK and LRCLK.
- Sits between the DAC FIFO read side and the codec's DACDAT pin. It supplies silence when the FIFO has no data.

Parameters:
- DATA_WIDTH, 16: bits per channel sample (legal 8..32).
- CNT_WIDTH, 8: width of the saturating underflow counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  level; permits frame sequencing
- bclk_rising_edge  input  1  1-cycle strobe, BCLK rose
- bclk_falling_edge  input  1  1-cycle strobe, BCLK fell
- lrclk_rising_edge  input  1  1-cycle strobe, LRCLK rose (right channel start)
- lrclk_falling_edge  input  1  1-cycle strobe, LRCLK fell (left channel/frame start)
- left_data  input  DATA_WIDTH  FIFO head, left sample
- right_data  input  DATA_WIDTH  FIFO head, right sample
- data_valid  input  1  FIFO non-empty; left/right_data valid
- data_ready  output  1  1-cycle read strobe; pair consumed
- serial_data  output  1  DACDAT to codec
- busy  output  1  high in LEFT or RIGHT state
- underflow  output  1  1-cycle pulse; frame started with no data
- underflow_count  output  CNT_WIDTH  saturating count of underflows

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, shift register=0, bit counter=0, holding regs=0. Outputs serial_data=0, data_ready=0, busy=0, underflow=0, underflow_count=0. Reset has priority over every other input and aborts any frame in progress immediately.
- States: IDLE, LEFT, RIGHT. busy = (state != IDLE).
- IDLE -> LEFT: on lrclk_falling_edge while enable=1. Any other strobe in IDLE is ignored, and serial_data holds 0.
- LEFT -> RIGHT: on lrclk_rising_edge.
- RIGHT -> LEFT or IDLE: on lrclk_falling_edge, go to LEFT if enable=1, else IDLE. Deasserting enable mid-frame always completes the current frame; it is sampled only at frame start.
- Frame start (entering LEFT):
  - If data_valid=1: latch left_data/right_data into holding regs and assert data_ready for exactly that cycle.
  - If data_valid=0: holding regs = 0, underflow pulses 1 cycle, and underflow_count increments, saturating at 2^CNT_WIDTH-1. data_ready stays 0.
- Channel load: same cycle as LEFT/RIGHT entry, the shift register loads the left/right holding value and the bit counter is set to DATA_WIDTH. The left load uses the value being latched that cycle, with no extra frame delay.
- Shift: on each bclk_falling_edge with bit counter > 0:
  - serial_data <= shift[MSB], shift <<= 1, counter -= 1.
  - With counter = 0, serial_data <= 0 (zero padding for slots longer than DATA_WIDTH).
- I2S one-bit delay: when an lrclk edge and a bclk_falling_edge occur in the same cycle (normal codec timing), the load wins and that bclk edge does not shift. serial_data drives 0 during that cycle's update, and the MSB appears on the next bclk_falling_edge.
- A truncated slot (LRCLK edge before the counter reaches 0) discards the remaining bits and reloads. This is not an error.
- bclk_rising_edge is unused for data. It is accepted only for port symmetry and must not affect state.
- Both lrclk strobes in the same cycle is illegal input and must be ignored (no state change).
- data_ready is never asserted outside a frame-start cycle. At most one pulse per frame.

Test Plan:
- Basic frame: enable=1, DATA_WIDTH=16, data_valid=1, left=16'hA5F0, right=16'h0F3C, BCLK=64·fs, edges aligned -> data_ready single pulse at LRCLK fall. DACDAT shows 1 zero bit, then A5F0 MSB-first, then 15 zeros; then 1 zero bit, then 0F3C, then 15 zeros.
- Underflow: data_valid=0 at three consecutive frame starts -> underflow pulses 3 times, underflow_count=3, serial_data all zeros, data_ready never asserted.
- Saturation: CNT_WIDTH=2, 5 underflow frames -> underflow_count stops at 3.
- Enable drop mid-frame: deassert enable during LEFT slot -> RIGHT slot fully shifted, state=IDLE and busy=0 after the next LRCLK fall, no data_ready.
- Short slot: BCLK=32·fs with DATA_WIDTH=24 -> 15 MSBs of each channel shifted, then reload at the LRCLK edge. No hang, and the next frame is correct.
- Reset mid-shift: assert reset at bit 7 of the left slot -> the next clk has serial_data=0, busy=0, counters 0. After release, no output until the next lrclk_falling_edge.
